// File: rtl/kmeans_regfile_pkg.sv
// Shared definitions for the k-means APB register file: register indices,
// status bit positions and the APB transfer FSM state encoding.
package kmeans_regfile_pkg;

  typedef enum logic [7:0] {
    internal_status_reg = 8'd0,
    go_reg              = 8'd1,
    cent_1_reg          = 8'd2,
    cent_2_reg          = 8'd3,
    cent_3_reg          = 8'd4,
    cent_4_reg          = 8'd5,
    cent_5_reg          = 8'd6,
    cent_6_reg          = 8'd7,
    cent_7_reg          = 8'd8,
    cent_8_reg          = 8'd9,
    ram_addr_reg        = 8'd10,
    ram_data_reg        = 8'd11,
    first_ram_addr_reg  = 8'd12,
    last_ram_addr_reg   = 8'd13
  } reg_idx_e;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } apb_state_e;

endpackage

// File: rtl/kmeans_apb_fsm.sv
// APB3 completer handshake: tracks setup/access phases, inserts one wait state
// for RAM_data writes, and produces pready, the commit strobe and ram_we.
module kmeans_apb_fsm
  import kmeans_regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic psel_i,
  input  logic penable_i,
  input  logic pwrite_i,
  input  logic ram_data_sel_i,
  input  logic ram_wr_allow_i,
  output logic pready_o,
  output logic commit_o,
  output logic ram_we_o
);

  apb_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping psel in ACCESS or WAIT abandons the transfer without pready.
  always_comb begin
    state_d  = state_q;
    pready_o = 1'b0;
    ram_we_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          if (pwrite_i && ram_data_sel_i) begin
            ram_we_o = ram_wr_allow_i;
            state_d  = WAIT;
          end else begin
            pready_o = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WAIT: begin
        pready_o = psel_i;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign commit_o = pready_o & pwrite_i;

endmodule

// File: rtl/kmeans_apb_regfile.sv
// k-means APB register file top: register storage, read mux and core hand-off.
// Define KMEANS_APB_PSLVERR_EN to add a pslverr output for unmapped or busy-blocked accesses.
module kmeans_apb_regfile
  import kmeans_regfile_pkg::*;
#(
  parameter int addrWidth     = 9,
  parameter int dataWidth     = 91,
  parameter int centroid_num  = 8,
  parameter int log2_cent_num = 3,
  parameter int ramAddrWidth  = 9
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [addrWidth-1:0]              paddr,
  input  logic                              pwrite,
  input  logic                              psel,
  input  logic                              penable,
  input  logic [dataWidth-1:0]              pwdata,
  output logic [dataWidth-1:0]              prdata,
  output logic                              pready,
`ifdef KMEANS_APB_PSLVERR_EN
  output logic                              pslverr,
`endif
  output logic                              interupt,
  output logic                              go_pulse,
  output logic [centroid_num*dataWidth-1:0] cent_out,
  output logic [ramAddrWidth-1:0]           first_ram_addr,
  output logic [ramAddrWidth-1:0]           last_ram_addr,
  output logic                              ram_we,
  output logic [ramAddrWidth-1:0]           ram_addr,
  output logic [dataWidth-1:0]              ram_wdata,
  input  logic                              core_done,
  input  logic                              cent_wr_en,
  input  logic [log2_cent_num-1:0]          cent_wr_idx,
  input  logic [dataWidth-1:0]              cent_wr_data
);

  reg_idx_e                 regSel;
  logic                     regMapped;
  logic                     isCent;
  logic                     wrAllowed;
  logic                     commit;
  logic [log2_cent_num-1:0] centIdx;
  logic [dataWidth-1:0]     rdMux;
  logic                     unused_addr_bits;

  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     goPulse_q, goPulse_d;
  logic [dataWidth-1:0]     cent_q [centroid_num];
  logic [dataWidth-1:0]     cent_d [centroid_num];
  logic [ramAddrWidth-1:0]  ramAddr_q, ramAddr_d;
  logic [dataWidth-1:0]     ramData_q, ramData_d;
  logic [ramAddrWidth-1:0]  first_q, first_d;
  logic [ramAddrWidth-1:0]  last_q, last_d;

  assign regSel           = reg_idx_e'(paddr[7:0]);
  assign unused_addr_bits = ^paddr[addrWidth-1:8];
  assign regMapped        = (regSel <= last_ram_addr_reg);
  assign isCent           = (regSel >= cent_1_reg) && (regSel <= cent_8_reg);
  assign centIdx          = log2_cent_num'(paddr[7:0] - 8'(cent_1_reg));
  // While the core runs, only the done W1C in status may still be written.
  assign wrAllowed        = !busy_q || (regSel == internal_status_reg);

  kmeans_apb_fsm u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .psel_i         (psel),
    .penable_i      (penable),
    .pwrite_i       (pwrite),
    .ram_data_sel_i (regSel == ram_data_reg),
    .ram_wr_allow_i (!busy_q),
    .pready_o       (pready),
    .commit_o       (commit),
    .ram_we_o       (ram_we)
  );

  // Core events are applied after the APB write so done-set and core write-back win.
  always_comb begin
    busy_d    = busy_q;
    done_d    = done_q;
    goPulse_d = 1'b0;
    cent_d    = cent_q;
    ramAddr_d = ramAddr_q;
    ramData_d = ramData_q;
    first_d   = first_q;
    last_d    = last_q;
    if (commit && wrAllowed) begin
      if (isCent) begin
        cent_d[centIdx] = pwdata;
      end
      case (regSel)
        internal_status_reg: if (pwdata[STATUS_DONE_BIT]) done_d = 1'b0;
        go_reg: begin
          if (pwdata[0]) begin
            goPulse_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
        ram_addr_reg:       ramAddr_d = pwdata[ramAddrWidth-1:0];
        ram_data_reg:       ramData_d = pwdata;
        first_ram_addr_reg: first_d   = pwdata[ramAddrWidth-1:0];
        last_ram_addr_reg:  last_d    = pwdata[ramAddrWidth-1:0];
        default: ;
      endcase
    end
    if (core_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (cent_wr_en) begin
      cent_d[cent_wr_idx] = cent_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      goPulse_q <= 1'b0;
      for (int k = 0; k < centroid_num; k++) begin
        cent_q[k] <= '0;
      end
      ramAddr_q <= '0;
      ramData_q <= '0;
      first_q   <= '0;
      last_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      goPulse_q <= goPulse_d;
      cent_q    <= cent_d;
      ramAddr_q <= ramAddr_d;
      ramData_q <= ramData_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    rdMux = '0;
    if (isCent) begin
      rdMux = cent_q[centIdx];
    end
    case (regSel)
      internal_status_reg: begin
        rdMux[STATUS_BUSY_BIT] = busy_q;
        rdMux[STATUS_DONE_BIT] = done_q;
      end
      ram_addr_reg:       rdMux = dataWidth'(ramAddr_q);
      ram_data_reg:       rdMux = ramData_q;
      first_ram_addr_reg: rdMux = dataWidth'(first_q);
      last_ram_addr_reg:  rdMux = dataWidth'(last_q);
      default: ;
    endcase
  end

  assign prdata = pready ? rdMux : '0;

`ifdef KMEANS_APB_PSLVERR_EN
  assign pslverr = pready & (!regMapped | (pwrite & !wrAllowed));
`endif

  generate
    for (genvar k = 0; k < centroid_num; k++) begin : g_cent_out
      assign cent_out[k*dataWidth +: dataWidth] = cent_q[k];
    end
  endgenerate

  assign interupt       = done_q;
  assign go_pulse       = goPulse_q;
  assign first_ram_addr = first_q;
  assign last_ram_addr  = last_q;
  assign ram_addr       = ramAddr_q;
  assign ram_wdata      = ram_we ? pwdata : ramData_q;

endmodule

// File: tb/tb_kmeans_apb_regfile.sv
// Self-checking bench for kmeans_apb_regfile: directed scenarios followed by
// randomized APB/core traffic compared against a transaction-level register model.
module tb_kmeans_apb_regfile;

  localparam int DW = 91;
  localparam int AW = 9;
  localparam int RW = 9;
  localparam int CN = 8;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic            psel;
  logic            penable;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;
`ifdef KMEANS_APB_PSLVERR_EN
  logic            pslverr;
`endif
  logic            interupt;
  logic            go_pulse;
  logic [CN*DW-1:0] cent_out;
  logic [RW-1:0]   first_ram_addr;
  logic [RW-1:0]   last_ram_addr;
  logic            ram_we;
  logic [RW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            core_done;
  logic            cent_wr_en;
  logic [2:0]      cent_wr_idx;
  logic [DW-1:0]   cent_wr_data;

  int checks = 0;
  int errors = 0;

  // Register model, updated once per completed transaction or core event.
  logic          mBusy;
  logic          mDone;
  logic [DW-1:0] mCent [CN];
  logic [RW-1:0] mRamAddr;
  logic [DW-1:0] mRamData;
  logic [RW-1:0] mFirst;
  logic [RW-1:0] mLast;

  kmeans_apb_regfile dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .paddr          (paddr),
    .pwrite         (pwrite),
    .psel           (psel),
    .penable        (penable),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
`ifdef KMEANS_APB_PSLVERR_EN
    .pslverr        (pslverr),
`endif
    .interupt       (interupt),
    .go_pulse       (go_pulse),
    .cent_out       (cent_out),
    .first_ram_addr (first_ram_addr),
    .last_ram_addr  (last_ram_addr),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .core_done      (core_done),
    .cent_wr_en     (cent_wr_en),
    .cent_wr_idx    (cent_wr_idx),
    .cent_wr_data   (cent_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mBusy    = 1'b0;
    mDone    = 1'b0;
    for (int k = 0; k < CN; k++) mCent[k] = '0;
    mRamAddr = '0;
    mRamData = '0;
    mFirst   = '0;
    mLast    = '0;
  endtask

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] addr);
    int sel;
    sel = int'(addr[7:0]);
    if (sel == 0) return DW'({mDone, mBusy});
    if (sel >= 2 && sel <= 9) return mCent[sel-2];
    if (sel == 10) return DW'(mRamAddr);
    if (sel == 11) return mRamData;
    if (sel == 12) return DW'(mFirst);
    if (sel == 13) return DW'(mLast);
    return '0;
  endfunction

  task automatic checkAll(input string tag);
    for (int k = 0; k < CN; k++) begin
      checkOutput($sformatf("%s.cent%0d", tag, k + 1), 128'(cent_out[k*DW +: DW]), 128'(mCent[k]));
    end
    checkOutput({tag, ".first"}, 128'(first_ram_addr), 128'(mFirst));
    checkOutput({tag, ".last"}, 128'(last_ram_addr), 128'(mLast));
    checkOutput({tag, ".ramAddr"}, 128'(ram_addr), 128'(mRamAddr));
    checkOutput({tag, ".interupt"}, 128'(interupt), 128'(mDone));
    checkOutput({tag, ".ramWeIdle"}, 128'(ram_we), 128'(0));
  endtask

  // One complete APB transfer; optionally pulses core_done on the commit edge.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic doneOnCommit);
    int sel;
    int waited;
    int weSeen;
    logic isRamW, mapped, blocked, expWe, expErr, goAcc;
    logic [DW-1:0] expRd;
    sel     = int'(addr[7:0]);
    isRamW  = wr && sel == 11;
    mapped  = sel <= 13;
    blocked = wr && mBusy && mapped && sel != 0;
    expWe   = isRamW && !mBusy;
    expErr  = !mapped || blocked;
    expRd   = modelRead(addr);
    goAcc   = wr && sel == 1 && data[0] && !mBusy;

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    waited = 0;
    weSeen = 0;
    @(negedge clk);
    while (!pready && waited < 4) begin
      if (ram_we) begin
        weSeen++;
        checkOutput("ramWeAddr", 128'(ram_addr), 128'(mRamAddr));
        checkOutput("ramWeData", 128'(ram_wdata), 128'(data));
      end
      @(negedge clk);
      waited++;
    end
    checkOutput("pready", 128'(pready), 128'(1));
    checkOutput("latency", 128'(waited), 128'(isRamW ? 1 : 0));
    checkOutput("ramWeCount", 128'(weSeen), 128'(expWe));
    checkOutput("ramWeAtReady", 128'(ram_we), 128'(0));
    if (!wr) checkOutput($sformatf("prdata@%0d", sel), 128'(prdata), 128'(expRd));
`ifdef KMEANS_APB_PSLVERR_EN
    checkOutput("pslverr", 128'(pslverr), 128'(expErr));
`else
    if (expErr && wr) checks = checks + 0;
`endif
    if (doneOnCommit) core_done = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; core_done = 1'b0;

    if (wr && (!mBusy || sel == 0)) begin
      if (sel == 0 && data[1]) mDone = 1'b0;
      if (goAcc) mBusy = 1'b1;
      if (sel >= 2 && sel <= 9) mCent[sel-2] = data;
      if (sel == 10) mRamAddr = data[RW-1:0];
      if (sel == 11) mRamData = data;
      if (sel == 12) mFirst = data[RW-1:0];
      if (sel == 13) mLast = data[RW-1:0];
    end
    if (doneOnCommit) begin
      mBusy = 1'b0;
      mDone = 1'b1;
    end

    @(negedge clk);
    checkOutput("goPulse", 128'(go_pulse), 128'(goAcc));
    checkOutput("preadyIdle", 128'(pready), 128'(0));
    @(negedge clk);
    checkOutput("goPulseOff", 128'(go_pulse), 128'(0));
  endtask

  task automatic pulseCoreDone();
    @(posedge clk); #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    mBusy = 1'b0;
    mDone = 1'b1;
    @(negedge clk);
  endtask

  task automatic coreWriteBack(input logic [2:0] idx, input logic [DW-1:0] data);
    @(posedge clk); #1;
    cent_wr_en = 1'b1; cent_wr_idx = idx; cent_wr_data = data;
    @(posedge clk); #1 cent_wr_en = 1'b0;
    mCent[idx] = data;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] randData();
    return DW'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    logic [DW-1:0] rdata;
    logic [AW-1:0] raddr;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; core_done = 1'b0; cent_wr_en = 1'b0;
    cent_wr_idx = '0; cent_wr_data = '0;
    modelReset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll("reset");
    checkOutput("resetGo", 128'(go_pulse), 128'(0));
    checkOutput("resetPready", 128'(pready), 128'(0));
    checkOutput("resetPrdata", 128'(prdata), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] centroid write/read");
    applyStimulus(1'b1, 9'd2, 91'd1, 1'b0);
    checkOutput("cent1Is1", 128'(cent_out[DW-1:0]), 128'(1));
    applyStimulus(1'b0, 9'd2, '0, 1'b0);
    checkAll("cent1");

    $display("[TB] RAM staging write");
    applyStimulus(1'b1, 9'd10, 91'd9, 1'b0);
    checkOutput("ramAddr9", 128'(ram_addr), 128'(9));
    applyStimulus(1'b1, 9'd11, {65'd0, 13'd7, 13'd0}, 1'b0);
    applyStimulus(1'b0, 9'd11, '0, 1'b0);
    checkAll("ram");

    $display("[TB] go sequence");
    applyStimulus(1'b1, 9'd12, 91'd1, 1'b0);
    applyStimulus(1'b1, 9'd13, 91'd10, 1'b0);
    applyStimulus(1'b1, 9'd1, 91'd1, 1'b0);
    applyStimulus(1'b0, 9'd0, '0, 1'b0);
    applyStimulus(1'b1, 9'd1, 91'd1, 1'b0);
    applyStimulus(1'b1, 9'd4, 91'd5, 1'b0);
    checkOutput("cent3Kept", 128'(cent_out[2*DW +: DW]), 128'(0));
    checkAll("busy");

    $display("[TB] done and interrupt");
    pulseCoreDone();
    checkOutput("interuptSet", 128'(interupt), 128'(1));
    applyStimulus(1'b0, 9'd0, '0, 1'b0);
    applyStimulus(1'b1, 9'd0, 91'd2, 1'b0);
    checkOutput("interuptClr", 128'(interupt), 128'(0));
    applyStimulus(1'b1, 9'd1, 91'd1, 1'b0);
    pulseCoreDone();
    applyStimulus(1'b1, 9'd1, 91'd1, 1'b0);
    applyStimulus(1'b1, 9'd0, 91'd2, 1'b1);
    checkOutput("interuptHeld", 128'(interupt), 128'(1));
    checkAll("doneRace");

    $display("[TB] abort");
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'd2; pwdata = 91'd123;
    @(posedge clk); #1 psel = 1'b0;
    @(negedge clk);
    checkOutput("abortPready", 128'(pready), 128'(0));
    checkOutput("abortPrdata", 128'(prdata), 128'(0));
    @(negedge clk);
    checkOutput("abortPready2", 128'(pready), 128'(0));
    checkAll("abort");

    $display("[TB] reset mid RAM_data transfer");
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'd11; pwdata = randData();
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    checkOutput("midRamWe", 128'(ram_we), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rstRamWe", 128'(ram_we), 128'(0));
    checkOutput("rstPready", 128'(pready), 128'(0));
    checkAll("midReset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stalePready", 128'(pready), 128'(0));
      checkOutput("staleRamWe", 128'(ram_we), 128'(0));
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    applyStimulus(1'b0, 9'd0, '0, 1'b0);
    applyStimulus(1'b0, 9'd11, '0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      raddr = AW'({$urandom_range(0, 1), 8'($urandom_range(0, 15))});
      rdata = randData();
      if (op <= 3) begin
        applyStimulus(1'b1, raddr, rdata, 1'b0);
      end else if (op <= 6) begin
        applyStimulus(1'b0, raddr, '0, 1'b0);
      end else if (op == 7) begin
        applyStimulus(1'b1, 9'd1, rdata, 1'b0);
      end else if (op == 8) begin
        if (mBusy) pulseCoreDone();
        else applyStimulus(1'b1, 9'd0, rdata, 1'b0);
      end else begin
        if (mBusy) coreWriteBack(3'($urandom_range(0, 7)), rdata);
        else applyStimulus(1'b0, 9'd0, '0, 1'b0);
      end
      checkAll($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmeans_apb_regfile.md
Name: kmeans_apb_regfile

Overview:
APB3 completer (responder) for the k-means accelerator; it is the slave-side counterpart of the bench/CPU APB initiator.
- Holds the control/status register map: status, go, 8 centroids, RAM staging address/data, first/last RAM address.
- Converts RAM_data writes into single-cycle RAM write strobes.
- Hands go/centroids/range to the core; accepts centroid write-back and a done pulse from the core; raises `interupt`.

Parameters:
- addrWidth, 9, APB address width; only the low 8 bits are decoded.
- dataWidth, 91, APB data width, also the centroid and RAM word width.
- centroid_num, 8, number of centroid registers.
- log2_cent_num, 3, width of the centroid index.
- ramAddrWidth, 9, RAM address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- paddr  in  addrWidth  APB address.
- pwrite  in  1  1 = write.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwdata  in  dataWidth  APB write data.
- prdata  out  dataWidth  APB read data; valid only while pready=1, otherwise 0.
- pready  out  1  transfer complete.
- interupt  out  1  level interrupt; set on core_done.
- go_pulse  out  1  one-cycle start strobe to the core.
- cent_out  out  centroid_num*dataWidth  centroid k occupies slice [k*dataWidth +: dataWidth].
- first_ram_addr  out  ramAddrWidth  first point address.
- last_ram_addr  out  ramAddrWidth  last point address.
- ram_we  out  1  one-cycle RAM write strobe.
- ram_addr  out  ramAddrWidth  RAM write address (staged register).
- ram_wdata  out  dataWidth  RAM write data.
- core_done  in  1  one-cycle iteration-complete pulse.
- cent_wr_en  in  1  core centroid write-back enable.
- cent_wr_idx  in  log2_cent_num  core write-back index.
- cent_wr_data  in  dataWidth  core write-back data.

Behaviour:
- Reset is asynchronous and active-low. On reset every register and output is 0 and the FSM is IDLE.
- Register map (paddr[7:0]):
  - 0 status: bit0 busy (RO); bit1 done (write 1 to clear).
  - 1 go: writing bit0=1 starts the core.
  - 2..9 cent_1..cent_8.
  - 10 RAM_addr.
  - 11 RAM_data.
  - 12 first_ram_addr.
  - 13 last_ram_addr.
  - Unmapped addresses: reads return 0; writes are ignored; pready still completes normally.
- FSM states: IDLE, ACCESS, WAIT.
  - IDLE→ACCESS on a setup phase (psel=1, penable=0).
  - In ACCESS with psel&penable:
    - RAM_data write: assert ram_we=1 for this cycle (ram_addr = staged RAM_addr, ram_wdata = pwdata), then go to WAIT.
    - Any other access: pready=1 this cycle, then go to IDLE.
  - WAIT: pready=1 for one cycle, then go to IDLE.
  - psel=0 in ACCESS or WAIT aborts the transfer: go to IDLE, no commit, no pready.
- Transfer latency: 1 cycle after setup for a normal access; 2 cycles for RAM_data (1 wait state).
- Register writes commit on the clock edge at which pready=1 and pwrite=1. The RAM_data holding register also updates on that edge.
- Reads: prdata is a combinational mux of the addressed register, gated by pready.
- go:
  - While busy=0: go_pulse=1 on the cycle after the commit, and busy is set on that same edge.
  - While busy=1: the go write is ignored; no pulse.
- Writes to centroids, RAM_addr, RAM_data, first or last while busy=1 are ignored (no ram_we). Reads are always allowed.
- core_done: clears busy, sets done and sets interupt on the next edge. interupt mirrors done.
- Simultaneous core_done and a W1C of the done bit: set wins, done stays 1.
- cent_wr_en=1 updates centroid cent_wr_idx on the next edge. This is legal only while busy; if an APB write to the same centroid commits on the same edge, the core write wins.
- Reset asserted mid-transfer: FSM returns to IDLE. If psel stays high after reset, nothing happens until a fresh setup phase (psel=1 with penable=0).

Optional Feature:
- Macro: KMEANS_APB_PSLVERR_EN.
- Defined: adds output port pslverr (1 bit), asserted together with pready when either:
  - the access is unmapped, or
  - a write is ignored because busy=1.
  Otherwise pslverr=0. Reset value 0.
- Undefined: no pslverr port; ignored and unmapped accesses complete silently.

Decomposition:
- Package kmeans_regfile_pkg holds:
  - the register-index enum (internal_status_reg .. last_ram_addr_reg, 8-bit);
  - the status bit positions;
  - the FSM state typedef.
- One sub-module, kmeans_apb_fsm, owns the IDLE/ACCESS/WAIT control and produces pready, the commit strobe and the ram_we strobe.
- Register storage and the read mux stay in the top of this block.

Test Plan:
- Write cent_1_reg=1, then read it back → cent_out[90:0]=1, prdata=1 during the pready cycle, 1-cycle access latency.
- Write RAM_addr=9, then RAM_data={65'd0,13'd7,13'd0} → ram_we high exactly 1 cycle with ram_addr=9 and ram_wdata=7<<13; pready asserted the following cycle.
- Write first=1, last=10, then go=1 → go_pulse single cycle; status reads 0x1; a second go while busy gives no pulse.
- While busy, write cent_3_reg=5 → cent_3 unchanged. With the macro defined, pslverr=1 on that transfer.
- Pulse core_done → interupt=1 and status=0x2. Write 2 to status → interupt=0. Repeat with core_done on the same edge as the clear → interupt stays 1.
- Abort: drop psel during ACCESS → no commit and no pready. Assert rst_n=0 mid RAM_data transfer → ram_we=0, all registers 0, FSM IDLE.
